// File: rtl/decode_pkg.sv
// Shared decoded-entry type and instruction field positions for the decode queue.
// The illegal bit exists only when DECODE_ILLEGAL_OP_EN is defined.
package decode_pkg;

  localparam int OP_HI    = 31;
  localparam int OP_LO    = 26;
  localparam int ALTOP_HI = 25;
  localparam int ALTOP_LO = 18;
  localparam int IMM_HI   = 23;
  localparam int IMM_LO   = 8;
  localparam int RD_HI    = 11;
  localparam int RD_LO    = 8;
  localparam int RS_HI    = 7;
  localparam int RS_LO    = 4;
  localparam int RT_HI    = 3;
  localparam int RT_LO    = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  op;
    logic [7:0]  altop;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic [31:0] imm32;
`ifdef DECODE_ILLEGAL_OP_EN
    logic        illegal;
`endif
  } decoded_entry_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/opcodes.sv
// Opcode values of the instruction set; decoder and illegal-op check key off these.
package opcodes;

  localparam logic [5:0] OPCODE_JAL  = 6'h03;
  localparam logic [5:0] OPCODE_BEQ  = 6'h04;
  localparam logic [5:0] OPCODE_BNE  = 6'h05;
  localparam logic [5:0] OPCODE_BLT  = 6'h06;
  localparam logic [5:0] OPCODE_BLE  = 6'h07;
  localparam logic [5:0] OPCODE_ADDI = 6'h08;
  localparam logic [5:0] OPCODE_ANDI = 6'h0C;
  localparam logic [5:0] OPCODE_ORI  = 6'h0D;
  localparam logic [5:0] OPCODE_XORI = 6'h0E;
  localparam logic [5:0] OPCODE_LW   = 6'h23;
  localparam logic [5:0] OPCODE_SW   = 6'h2B;

endpackage

// File: rtl/decode_queue.sv
// DEPTH-entry FIFO of decoded entries with occupancy count, synchronous flush
// and asynchronous active-low reset; head reads as zero while empty.
module decode_queue
  import decode_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  decoded_entry_t               push_entry_i,
  output decoded_entry_t               head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = $clog2(DEPTH);

  decoded_entry_t   mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

  // No fall-through: a full queue refuses a word even if the head leaves this cycle.
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: it is only observable through a non-empty head.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
  end

  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/decode_queue_stage.sv
// Decode stage: combinational instruction decode feeding a decoded-entry queue.
// Optional macro DECODE_ILLEGAL_OP_EN adds a per-entry illegal-opcode flag.
module decode_queue_stage
  import decode_pkg::*;
  import opcodes::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       fetch_valid,
  output logic                       fetch_ready,
  input  logic [PC_W-1:0]            fetch_pc,
  input  logic [31:0]                fetch_inst,
  input  logic                       rr_ready,
  input  logic                       rr_flush,
  output logic                       decode_valid,
  output logic [PC_W-1:0]            decode_pc,
  output logic [5:0]                 decode_op,
  output logic [7:0]                 decode_altop,
  output logic [3:0]                 decode_rd,
  output logic [3:0]                 decode_rs,
  output logic [3:0]                 decode_rt,
  output logic [PC_W-1:0]            decode_imm32,
`ifdef DECODE_ILLEGAL_OP_EN
  output logic                       decode_illegal,
`endif
  output logic [$clog2(DEPTH+1)-1:0] decode_count
);

  decoded_entry_t dec_d;
  decoded_entry_t head;
  logic [5:0]     op;
  logic [15:0]    imm16;
  logic [3:0]     rd_f, rs_f, rt_f;
  logic           accept_en_q;
  logic           q_full;
  logic           q_empty;

  assign op    = fetch_inst[OP_HI:OP_LO];
  assign imm16 = fetch_inst[IMM_HI:IMM_LO];
  assign rd_f  = fetch_inst[RD_HI:RD_LO];
  assign rs_f  = fetch_inst[RS_HI:RS_LO];
  assign rt_f  = fetch_inst[RT_HI:RT_LO];

  always_comb begin
    dec_d       = '0;
    dec_d.pc    = fetch_pc;
    dec_d.op    = op;
    dec_d.altop = fetch_inst[ALTOP_HI:ALTOP_LO];
    dec_d.rs    = rs_f;
    case (op)
      6'h00: begin
        dec_d.rd    = rd_f;
        dec_d.rt    = rt_f;
        dec_d.imm32 = '0;
      end
      OPCODE_BEQ, OPCODE_BLT, OPCODE_BLE, OPCODE_BNE: begin
        dec_d.rt    = rt_f;
        dec_d.imm32 = fetch_pc + 32'd4 + (sext16(imm16) << 2);
      end
      OPCODE_JAL: begin
        dec_d.rd    = rt_f;
        dec_d.imm32 = sext16(imm16) << 2;
      end
      OPCODE_LW: begin
        dec_d.rd    = rt_f;
        dec_d.imm32 = sext16(imm16);
      end
      OPCODE_SW: begin
        dec_d.rt    = rt_f;
        dec_d.imm32 = sext16(imm16);
      end
      default: begin
        // Every unrecognised op, legal or not, is treated as an ALU-immediate.
        dec_d.rd    = rt_f;
        dec_d.imm32 = sext16(imm16);
        dec_d.altop = {2'b00, op};
      end
    endcase
`ifdef DECODE_ILLEGAL_OP_EN
    dec_d.illegal = !(op inside {6'h00, OPCODE_JAL, OPCODE_BEQ, OPCODE_BNE, OPCODE_BLT,
                                 OPCODE_BLE, OPCODE_ADDI, OPCODE_ANDI, OPCODE_ORI,
                                 OPCODE_XORI, OPCODE_LW, OPCODE_SW});
`endif
  end

  // Blocks acceptance on the first edge after reset release.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) accept_en_q <= 1'b0;
    else            accept_en_q <= 1'b1;
  end

  decode_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk_i        (i_clk),
    .rst_ni       (i_reset_n),
    .flush_i      (rr_flush),
    .push_i       (fetch_valid && accept_en_q),
    .pop_i        (rr_ready),
    .push_entry_i (dec_d),
    .head_o       (head),
    .count_o      (decode_count),
    .full_o       (q_full),
    .empty_o      (q_empty)
  );

  assign fetch_ready  = !q_full;
  assign decode_valid = !q_empty;
  assign decode_pc    = head.pc;
  assign decode_op    = head.op;
  assign decode_altop = head.altop;
  assign decode_rd    = head.rd;
  assign decode_rs    = head.rs;
  assign decode_rt    = head.rt;
  assign decode_imm32 = head.imm32;
`ifdef DECODE_ILLEGAL_OP_EN
  assign decode_illegal = head.illegal;
`endif

endmodule

// File: tb/tb_decode_queue_stage.sv
// Scoreboard bench for decode_queue_stage: reference model queue vs DUT head/count.
module tb_decode_queue_stage;
  import opcodes::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_valid, fetch_ready, rr_ready, rr_flush, decode_valid;
  logic [31:0] fetch_pc, fetch_inst, decode_pc, decode_imm32;
  logic [5:0]  decode_op;
  logic [7:0]  decode_altop;
  logic [3:0]  decode_rd, decode_rs, decode_rt;
  logic [2:0]  decode_count;
`ifdef DECODE_ILLEGAL_OP_EN
  logic        decode_illegal;
`endif

  always #5 clk = ~clk;

  decode_queue_stage #(.DEPTH(DEPTH), .PC_W(32)) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .fetch_valid  (fetch_valid),
    .fetch_ready  (fetch_ready),
    .fetch_pc     (fetch_pc),
    .fetch_inst   (fetch_inst),
    .rr_ready     (rr_ready),
    .rr_flush     (rr_flush),
    .decode_valid (decode_valid),
    .decode_pc    (decode_pc),
    .decode_op    (decode_op),
    .decode_altop (decode_altop),
    .decode_rd    (decode_rd),
    .decode_rs    (decode_rs),
    .decode_rt    (decode_rt),
    .decode_imm32 (decode_imm32),
`ifdef DECODE_ILLEGAL_OP_EN
    .decode_illegal (decode_illegal),
`endif
    .decode_count (decode_count)
  );

  typedef struct {
    logic [31:0] pc;
    logic [5:0]  op;
    logic [7:0]  altop;
    logic [3:0]  rd, rs, rt;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   started_m = 0;
  bit   deq_m = 0;

  // Reference decode straight from the instruction-set rules, using signed arithmetic.
  function automatic exp_t model(input logic [31:0] pc, input logic [31:0] inst);
    exp_t        e;
    int          s;
    logic [15:0] f16;
    logic [5:0]  op;
    f16 = inst[23:8];
    s = int'($signed(f16));
    op = inst[31:26];
    e.pc = pc; e.op = op; e.altop = inst[25:18]; e.ill = 1'b0;
    e.rd = 4'h0; e.rs = inst[7:4]; e.rt = 4'h0;
    if (op == 6'h00) begin
      e.rd = inst[11:8]; e.rt = inst[3:0]; e.imm = 32'h0;
    end else if (op == OPCODE_BEQ || op == OPCODE_BLT || op == OPCODE_BLE || op == OPCODE_BNE) begin
      e.rt = inst[3:0]; e.imm = pc + 32'(4 + s * 4);
    end else if (op == OPCODE_JAL) begin
      e.rd = inst[3:0]; e.imm = 32'(s * 4);
    end else if (op == OPCODE_LW) begin
      e.rd = inst[3:0]; e.imm = 32'(s);
    end else if (op == OPCODE_SW) begin
      e.rt = inst[3:0]; e.imm = 32'(s);
    end else begin
      e.rd = inst[3:0]; e.imm = 32'(s); e.altop = {2'b00, op};
      e.ill = !(op == OPCODE_ADDI || op == OPCODE_ANDI || op == OPCODE_ORI || op == OPCODE_XORI);
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual %0h required %0h", name, $time, act, exp);
    end
  endtask

  // Scoreboard push side: words accepted at each edge enter the expected queue.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      started_m = 0;
      deq_m = 0;
    end else begin
      int pre;
      pre = exp_q.size() + (deq_m ? 1 : 0);
      if (rr_flush) exp_q.delete();
      else if (fetch_valid && pre != DEPTH && started_m) exp_q.push_back(model(fetch_pc, fetch_inst));
      deq_m = 0;
      started_m = 1;
    end
  end

  // Monitor: compare the presented head and status, pop on a consumed head.
  always @(negedge clk) begin
    logic [89:0] act, expv;
    act = {decode_pc, decode_op, decode_altop, decode_rd, decode_rs, decode_rt, decode_imm32};
    expv = '0;
    if (exp_q.size() != 0)
      expv = {exp_q[0].pc, exp_q[0].op, exp_q[0].altop, exp_q[0].rd, exp_q[0].rs,
              exp_q[0].rt, exp_q[0].imm};
    check("count", 128'(decode_count), 128'(exp_q.size()));
    check("decode_valid", 128'(decode_valid), 128'(exp_q.size() != 0));
    check("fetch_ready", 128'(fetch_ready), 128'(exp_q.size() != DEPTH));
    check("head_entry", 128'(act), 128'(expv));
`ifdef DECODE_ILLEGAL_OP_EN
    check("decode_illegal", 128'(decode_illegal), 128'(exp_q.size() != 0 ? exp_q[0].ill : 1'b0));
`endif
    if (rst_n && !rr_flush && rr_ready && exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      deq_m = 1;
    end
  end

  task automatic step(input bit v, input logic [31:0] pc, input logic [31:0] inst,
                      input bit rdy, input bit fl);
    fetch_valid = v; fetch_pc = pc; fetch_inst = inst; rr_ready = rdy; rr_flush = fl;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [5:0] op;
    case ($urandom_range(0, 9))
      0: op = 6'h00;       1: op = OPCODE_BEQ;  2: op = OPCODE_BNE;
      3: op = OPCODE_BLT;  4: op = OPCODE_BLE;  5: op = OPCODE_JAL;
      6: op = OPCODE_LW;   7: op = OPCODE_SW;   8: op = OPCODE_ADDI;
      default: op = 6'($urandom);
    endcase
    return {op, 26'($urandom)};
  endfunction

  localparam logic [31:0] ADDI_W = {6'h08, 2'b00, 16'h8001, 8'h53};

  initial begin
    rst_n = 1'b0;
    fetch_valid = 0; fetch_pc = 0; fetch_inst = 0; rr_ready = 0; rr_flush = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 128'(fetch_ready), 128'(1));
    // Word offered across release is not taken on the first edge.
    fetch_valid = 1; fetch_pc = 32'h40; fetch_inst = ADDI_W;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("release_no_accept", 128'(decode_count), 128'(0));
    step(1, 32'h40, ADDI_W, 0, 0);
    check("first_accept", 128'(decode_count), 128'(1));
    check("alui_imm", 128'(decode_imm32), 128'(32'hFFFF_8001));
    step(0, 0, 0, 1, 0);

    // Branch with negative offset lands back on its own PC.
    step(1, 32'h100, {OPCODE_BEQ, 2'b00, 16'hFFFF, 8'h21}, 0, 0);
    check("beq_valid", 128'(decode_valid), 128'(1));
    check("beq_imm32", 128'(decode_imm32), 128'(32'h100));
    check("beq_rd", 128'(decode_rd), 128'(0));
    step(0, 0, 0, 1, 0);

    // Fill: fifth word is refused while full.
    for (int i = 0; i < 5; i++) begin
      step(1, 32'h200 + 32'(i * 4), {OPCODE_LW, 10'(i), 16'(i * 16 + 3)}, 0, 0);
      if (i >= 3) begin
        check("fill_ready", 128'(fetch_ready), 128'(0));
        check("fill_count", 128'(decode_count), 128'(4));
      end
    end
    for (int i = 0; i < 4; i++) begin
      check("drain_pc", 128'(decode_pc), 128'(32'h200 + 32'(i * 4)));
      step(0, 0, 0, 1, 0);
    end
    check("drain_empty", 128'(decode_count), 128'(0));

    // Concurrent enqueue/dequeue across pointer wrap.
    for (int i = 0; i < 2; i++) step(1, 32'h300 + 32'(i * 4), rand_inst(), 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(1, 32'h400 + 32'(i * 4), rand_inst(), 1, 0);
      check("concurrent_count", 128'(decode_count), 128'(2));
    end
    step(0, 0, 0, 1, 0); step(0, 0, 0, 1, 0);

    // Flush with a word offered in the same cycle.
    for (int i = 0; i < 3; i++) step(1, 32'h500 + 32'(i * 4), rand_inst(), 0, 0);
    step(1, 32'h5F0, rand_inst(), 1, 1);
    check("flush_count", 128'(decode_count), 128'(0));
    check("flush_valid", 128'(decode_valid), 128'(0));
    check("flush_pc", 128'(decode_pc), 128'(0));
    step(0, 0, 0, 0, 0);
    check("flush_word_absent", 128'(decode_count), 128'(0));

    // Asynchronous reset mid-cycle.
    for (int i = 0; i < 2; i++) step(1, 32'h600 + 32'(i * 4), rand_inst(), 0, 0);
    #2; rst_n = 1'b0; #1;
    check("async_reset_valid", 128'(decode_valid), 128'(0));
    check("async_reset_count", 128'(decode_count), 128'(0));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_release_count", 128'(decode_count), 128'(0));
    step(0, 0, 0, 1, 0);

`ifdef DECODE_ILLEGAL_OP_EN
    step(1, 32'h700, {6'h3F, 26'h0012345}, 0, 0);
    check("illegal_flag", 128'(decode_illegal), 128'(1));
    check("illegal_altop", 128'(decode_altop), 128'(8'h3F));
    step(0, 0, 0, 1, 0);
    step(1, 32'h704, {OPCODE_LW, 26'h0012345}, 0, 0);
    check("legal_lw_flag", 128'(decode_illegal), 128'(0));
    step(0, 0, 0, 1, 0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, {$urandom, 2'b00} >> 2 << 2, rand_inst(),
           $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
    for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 0, 1, 0);
    check("final_empty", 128'(decode_count), 128'(0));

    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
